// File: rtl/hwpe_stream_tcdm_load_buffer_if.sv
// TCDM port bundle: request channel plus one-cycle-later read response.
// Latency: none, pure signal bundle.
// Backpressure: req/gnt handshake on requests, r_valid carries no stall.
interface hwpe_stream_intf_tcdm;
    logic        req;
    logic        gnt;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] r_data;
    logic        r_valid;

    modport master (
        output req, add, wen, be, data,
        input  gnt, r_data, r_valid
    );

    modport slave (
        input  req, add, wen, be, data,
        output gnt, r_data, r_valid
    );
endinterface

// File: rtl/hwpe_stream_tcdm_load_buffer.sv
// Generic occupancy-counted FIFO, registered output, no fall-through.
// Latency: a pushed word is visible at the head one cycle after the push.
// Backpressure: caller must respect full/empty; head data is zero while empty.
module lb_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdat,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    cnt;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    // Head is forced to zero while empty so stale storage never leaks out.
    assign rdat  = empty ? '0 : mem[rptr];

    // Storage array: written on push, never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wdat;
        end
    end

    // Pointers wrap naturally (power-of-two depth); occupancy drives full/empty.
    always_ff @(posedge clk) begin
        if (clr) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !pop) begin
                cnt <= cnt + CW'(1);
            end else if (!push && pop) begin
                cnt <= cnt - CW'(1);
            end
        end
    end
endmodule

// Load decoupling buffer: HWPE load requests -> TCDM, read data -> HWPE consumer.
// Latency: slave grant to master req >= 1 cycle; master r_valid to slave r_valid >= 1 cycle.
// Backpressure: slave gnt drops when request FIFO full; issue stalls until response space is reserved.
module hwpe_stream_tcdm_load_buffer #(
    parameter int unsigned REQ_DEPTH  = 4,
    parameter int unsigned RESP_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clear_i,
    hwpe_stream_intf_tcdm.slave           tcdm_slave,
    input  logic                          ready_i,
    hwpe_stream_intf_tcdm.master          tcdm_master,
    output logic                          req_empty_o,
    output logic                          resp_full_o,
    output logic [$clog2(RESP_DEPTH):0]   pending_o
);
    localparam int unsigned PW = $clog2(RESP_DEPTH) + 1;
    localparam int unsigned SW = PW + 1;
    localparam int unsigned RW = $clog2(REQ_DEPTH) + 1;

    logic          clr;
    logic          slave_gnt;
    logic          req_push;
    logic          req_pop;
    logic          req_full;
    logic          req_empty;
    logic [35:0]   req_head;
    logic [RW-1:0] req_count_unused;

    logic          resp_push;
    logic          resp_pop;
    logic          resp_full;
    logic          resp_empty;
    logic [31:0]   resp_head;
    logic [PW-1:0] resp_count;

    logic [PW-1:0] pending_q;
    logic [SW-1:0] credit_sum;
    logic          credit_ok;
    logic          mst_req;
    logic          unused_slave_fields;

    assign clr = rst_i || clear_i;

    // Loads only: write enable and write data from the HWPE are not used.
    assign unused_slave_fields = ^{tcdm_slave.wen, tcdm_slave.data};

    // Request side: no pass-through, so a pop never frees a slot the same cycle.
    assign slave_gnt = !req_full && !clear_i;
    assign req_push  = tcdm_slave.req && slave_gnt;

    // A request may only issue if its response is guaranteed a FIFO slot.
    assign credit_sum = {1'b0, pending_q} + {1'b0, resp_count};
    assign credit_ok  = (credit_sum < SW'(RESP_DEPTH));
    assign mst_req    = !req_empty && credit_ok;
    assign req_pop    = mst_req && tcdm_master.gnt;

    // Responses with nothing outstanding are leftovers from before a reset/clear.
    assign resp_push = tcdm_master.r_valid && (pending_q != '0);
    assign resp_pop  = !resp_empty && ready_i;

    lb_fifo #(
        .WIDTH (36),
        .DEPTH (REQ_DEPTH)
    ) i_req_fifo (
        .clk   (clk_i),
        .clr   (clr),
        .push  (req_push),
        .wdat  ({tcdm_slave.be, tcdm_slave.add}),
        .pop   (req_pop),
        .rdat  (req_head),
        .count (req_count_unused),
        .full  (req_full),
        .empty (req_empty)
    );

    lb_fifo #(
        .WIDTH (32),
        .DEPTH (RESP_DEPTH)
    ) i_resp_fifo (
        .clk   (clk_i),
        .clr   (clr),
        .push  (resp_push),
        .wdat  (tcdm_master.r_data),
        .pop   (resp_pop),
        .rdat  (resp_head),
        .count (resp_count),
        .full  (resp_full),
        .empty (resp_empty)
    );

    // Outstanding-read counter: up on master grant, down on an accepted response.
    always_ff @(posedge clk_i) begin
        if (clr) begin
            pending_q <= '0;
        end else if (req_pop && !resp_push) begin
            pending_q <= pending_q + PW'(1);
        end else if (!req_pop && resp_push) begin
            pending_q <= pending_q - PW'(1);
        end
    end

    // Credit scheme must make a push into a full response FIFO unreachable.
    resp_overflow_a : assert property (@(posedge clk_i) disable iff (clr)
        !(resp_push && resp_full));

    assign tcdm_slave.gnt     = slave_gnt;
    assign tcdm_slave.r_valid = !resp_empty;
    assign tcdm_slave.r_data  = resp_head;

    assign tcdm_master.req    = mst_req;
    assign tcdm_master.add    = req_head[31:0];
    assign tcdm_master.be     = req_head[35:32];
    assign tcdm_master.wen    = 1'b1;
    assign tcdm_master.data   = 32'h0;

    assign req_empty_o = req_empty;
    assign resp_full_o = resp_full;
    assign pending_o   = pending_q;
endmodule

// File: tb/tb_hwpe_stream_tcdm_load_buffer.sv
// Bench for the TCDM load buffer: TCDM memory model plus ordered-response reference.
// Latency: memory answers exactly one cycle after each master grant.
// Backpressure: master gnt and ready are driven per scenario, randomly in the soak test.
module tb_hwpe_stream_tcdm_load_buffer;
    localparam int REQ_DEPTH  = 4;
    localparam int RESP_DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                          rst;
    logic                          clear;
    logic                          ready;
    logic                          req_empty;
    logic                          resp_full;
    logic [$clog2(RESP_DEPTH):0]   pending;

    hwpe_stream_intf_tcdm slv ();
    hwpe_stream_intf_tcdm mst ();

    hwpe_stream_tcdm_load_buffer #(
        .REQ_DEPTH  (REQ_DEPTH),
        .RESP_DEPTH (RESP_DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (clear),
        .tcdm_slave  (slv),
        .ready_i     (ready),
        .tcdm_master (mst),
        .req_empty_o (req_empty),
        .resp_full_o (resp_full),
        .pending_o   (pending)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] feed_q  [$];
    logic [31:0] grant_q [$];
    logic [31:0] got_q   [$];
    int          n_grants;
    int          inflight;
    int          resp_held;
    int          credit_viol;
    logic        last_push;
    logic        last_grant;
    logic        rand_mode;

    // Memory contents: distinct for distinct 24-bit addresses; 0x100 -> 0xCAFE0001.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {16'hCAFE ^ {8'h00, a[7:0]}, a[23:8]};
    endfunction

    // One clock: sample both handshakes mid-cycle, then play the TCDM response.
    task automatic tick();
        logic        g;
        logic [31:0] ga;
        @(negedge clk);
        g          = mst.req && mst.gnt;
        ga         = mst.add;
        last_push  = slv.req && slv.gnt;
        last_grant = g;
        if (!(rst || clear)) begin
            if (int'(pending) + resp_held > RESP_DEPTH) credit_viol++;
            if (g) begin
                grant_q.push_back(ga);
                n_grants++;
            end
            if (slv.r_valid && ready) begin
                got_q.push_back(slv.r_data);
                resp_held--;
            end
            if (mst.r_valid && inflight > 0) begin
                resp_held++;
                inflight--;
            end
            if (g) inflight++;
        end else begin
            resp_held = 0;
            inflight  = 0;
        end
        @(posedge clk);
        #1;
        mst.r_valid = g;
        mst.r_data  = g ? mem_fn(ga) : 32'h0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            if (rand_mode) begin
                mst.gnt = ($urandom % 4) != 0;
                ready   = ($urandom % 3) != 0;
            end
            if (feed_q.size() > 0 && (!rand_mode || ($urandom % 4) != 0)) begin
                slv.req = 1'b1;
                slv.add = feed_q[0];
            end else begin
                slv.req = 1'b0;
            end
            tick();
            if (last_push) void'(feed_q.pop_front());
        end
        slv.req = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget);
        for (int i = 0; i < budget && got_q.size() < n; i++) run(1);
    endtask

    task automatic clr_stats();
        feed_q.delete();
        grant_q.delete();
        got_q.delete();
        n_grants    = 0;
        credit_viol = 0;
    endtask

    task automatic reset_dut();
        rst     = 1'b1;
        slv.req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        clr_stats();
    endtask

    task automatic test_reset();
        reset_dut();
        checks++; if (slv.gnt !== 1'b1) begin failures++; $display("FAIL reset_slave_gnt got=%0b exp=1", slv.gnt); end
        checks++; if (slv.r_valid !== 1'b0) begin failures++; $display("FAIL reset_slave_rvalid got=%0b exp=0", slv.r_valid); end
        checks++; if (slv.r_data !== 32'h0) begin failures++; $display("FAIL reset_slave_rdata got=%h exp=0", slv.r_data); end
        checks++; if (mst.req !== 1'b0) begin failures++; $display("FAIL reset_master_req got=%0b exp=0", mst.req); end
        checks++; if (req_empty !== 1'b1) begin failures++; $display("FAIL reset_req_empty got=%0b exp=1", req_empty); end
        checks++; if (resp_full !== 1'b0) begin failures++; $display("FAIL reset_resp_full got=%0b exp=0", resp_full); end
        checks++; if (pending !== '0) begin failures++; $display("FAIL reset_pending got=%0d exp=0", pending); end
    endtask

    task automatic test_single_load();
        reset_dut();
        mst.gnt = 1'b1;
        ready   = 1'b1;
        slv.req = 1'b1;
        slv.add = 32'h100;
        #1;
        checks++; if (slv.gnt !== 1'b1) begin failures++; $display("FAIL single_c0_gnt got=%0b exp=1", slv.gnt); end
        checks++; if (mst.req !== 1'b0) begin failures++; $display("FAIL single_c0_mreq got=%0b exp=0", mst.req); end
        tick();
        slv.req = 1'b0;
        checks++; if (mst.req !== 1'b1 || mst.add !== 32'h100 || mst.wen !== 1'b1 || mst.be !== 4'hF)
            begin failures++; $display("FAIL single_c1_mreq got=%0b/%h/%0b/%h exp=1/00000100/1/f", mst.req, mst.add, mst.wen, mst.be); end
        checks++; if (pending !== 3'd0) begin failures++; $display("FAIL single_c1_pending got=%0d exp=0", pending); end
        tick();
        checks++; if (pending !== 3'd1) begin failures++; $display("FAIL single_c2_pending got=%0d exp=1", pending); end
        checks++; if (slv.r_valid !== 1'b0) begin failures++; $display("FAIL single_c2_rvalid got=%0b exp=0", slv.r_valid); end
        tick();
        checks++; if (slv.r_valid !== 1'b1 || slv.r_data !== 32'hCAFE0001)
            begin failures++; $display("FAIL single_c3_resp got=%0b/%h exp=1/cafe0001", slv.r_valid, slv.r_data); end
        checks++; if (pending !== 3'd0) begin failures++; $display("FAIL single_c3_pending got=%0d exp=0", pending); end
        tick();
        checks++; if (slv.r_valid !== 1'b0) begin failures++; $display("FAIL single_c4_drained got=%0b exp=0", slv.r_valid); end
    endtask

    task automatic test_req_backpressure();
        logic [31:0] sent [$];
        int bad;
        reset_dut();
        mst.gnt = 1'b0;
        ready   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sent.push_back({8'h00, 24'($urandom)});
            feed_q.push_back(sent[i]);
        end
        run(8);
        checks++; if (REQ_DEPTH + feed_q.size() != 6) begin failures++; $display("FAIL bp_accepted got=%0d exp=%0d", 6 - feed_q.size(), REQ_DEPTH); end
        checks++; if (slv.gnt !== 1'b0) begin failures++; $display("FAIL bp_slave_gnt got=%0b exp=0", slv.gnt); end
        checks++; if (n_grants != 0) begin failures++; $display("FAIL bp_no_issue got=%0d exp=0", n_grants); end
        mst.gnt = 1'b1;
        wait_done(6, 100);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (i >= grant_q.size() || grant_q[i] !== sent[i]) bad++;
            if (i >= got_q.size() || got_q[i] !== mem_fn(sent[i])) bad++;
        end
        checks++; if (bad != 0 || got_q.size() != 6) begin failures++; $display("FAIL bp_order got_bad=%0d got_n=%0d exp_bad=0 exp_n=6", bad, got_q.size()); end
    endtask

    task automatic test_credit_limit();
        logic [31:0] sent [$];
        int bad;
        reset_dut();
        mst.gnt = 1'b1;
        ready   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sent.push_back({8'h00, 24'($urandom)});
            feed_q.push_back(sent[i]);
        end
        run(20);
        checks++; if (n_grants != RESP_DEPTH) begin failures++; $display("FAIL credit_grants got=%0d exp=%0d", n_grants, RESP_DEPTH); end
        checks++; if (mst.req !== 1'b0) begin failures++; $display("FAIL credit_mreq got=%0b exp=0", mst.req); end
        checks++; if (resp_full !== 1'b1) begin failures++; $display("FAIL credit_resp_full got=%0b exp=1", resp_full); end
        ready = 1'b1;
        wait_done(8, 200);
        bad = 0;
        for (int i = 0; i < 8; i++)
            if (i >= got_q.size() || got_q[i] !== mem_fn(sent[i])) bad++;
        checks++; if (bad != 0 || n_grants != 8) begin failures++; $display("FAIL credit_data got_bad=%0d grants=%0d exp_bad=0 grants=8", bad, n_grants); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] sent [$];
        int bad_pend, bad_vld, g0, bad;
        reset_dut();
        mst.gnt = 1'b1;
        ready   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sent.push_back({8'h00, 24'($urandom)});
            feed_q.push_back(sent[i]);
        end
        run(4);
        bad_pend = 0;
        bad_vld  = 0;
        g0       = n_grants;
        for (int i = 0; i < 10; i++) begin
            if (pending !== 3'd1) bad_pend++;
            if (slv.r_valid !== 1'b1) bad_vld++;
            run(1);
        end
        checks++; if (n_grants - g0 != 10) begin failures++; $display("FAIL b2b_rate got=%0d exp=10", n_grants - g0); end
        checks++; if (bad_pend != 0) begin failures++; $display("FAIL b2b_pending got_bad=%0d exp=0", bad_pend); end
        checks++; if (bad_vld != 0) begin failures++; $display("FAIL b2b_rvalid got_bad=%0d exp=0", bad_vld); end
        wait_done(16, 100);
        bad = 0;
        for (int i = 0; i < 16; i++)
            if (i >= got_q.size() || got_q[i] !== mem_fn(sent[i])) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL b2b_data got_bad=%0d exp=0", bad); end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        mst.gnt = 1'b1;
        ready   = 1'b1;
        feed_q.push_back(32'h200);
        for (int i = 0; i < 10 && !last_grant; i++) run(1);
        checks++; if (last_grant !== 1'b1) begin failures++; $display("FAIL rmid_grant got=%0b exp=1", last_grant); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mst.r_valid = 1'b1;
        mst.r_data  = 32'hDEAD;
        #1;
        checks++; if (slv.gnt !== 1'b1 || slv.r_valid !== 1'b0 || mst.req !== 1'b0)
            begin failures++; $display("FAIL rmid_outputs got=%0b/%0b/%0b exp=1/0/0", slv.gnt, slv.r_valid, mst.req); end
        checks++; if (pending !== '0 || req_empty !== 1'b1 || resp_full !== 1'b0)
            begin failures++; $display("FAIL rmid_status got=%0d/%0b/%0b exp=0/1/0", pending, req_empty, resp_full); end
        tick();
        checks++; if (slv.r_valid !== 1'b0 || pending !== '0)
            begin failures++; $display("FAIL rmid_stale got=%0b/%0d exp=0/0", slv.r_valid, pending); end
        clr_stats();
        feed_q.push_back(32'h300);
        wait_done(1, 20);
        checks++; if (got_q.size() != 1 || got_q[0] !== mem_fn(32'h300))
            begin failures++; $display("FAIL rmid_next got_n=%0d got=%h exp=%h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'h0, mem_fn(32'h300)); end
    endtask

    task automatic test_clear();
        reset_dut();
        mst.gnt = 1'b1;
        ready   = 1'b0;
        for (int i = 0; i < 6; i++) feed_q.push_back(32'h1000 + 32'(i * 4));
        run(14);
        checks++; if (resp_full !== 1'b1 || req_empty !== 1'b0)
            begin failures++; $display("FAIL clr_prefill got=%0b/%0b exp=1/0", resp_full, req_empty); end
        clear   = 1'b1;
        slv.req = 1'b1;
        slv.add = 32'h999;
        #1;
        checks++; if (slv.gnt !== 1'b0) begin failures++; $display("FAIL clr_gnt got=%0b exp=0", slv.gnt); end
        tick();
        clear   = 1'b0;
        slv.req = 1'b0;
        #1;
        checks++; if (req_empty !== 1'b1 || resp_full !== 1'b0 || pending !== '0)
            begin failures++; $display("FAIL clr_status got=%0b/%0b/%0d exp=1/0/0", req_empty, resp_full, pending); end
        checks++; if (slv.r_valid !== 1'b0 || slv.r_data !== 32'h0 || mst.req !== 1'b0 || slv.gnt !== 1'b1)
            begin failures++; $display("FAIL clr_outputs got=%0b/%h/%0b/%0b exp=0/0/0/1", slv.r_valid, slv.r_data, mst.req, slv.gnt); end
        clr_stats();
        ready = 1'b1;
        feed_q.push_back(32'h400);
        wait_done(1, 20);
        checks++; if (got_q.size() != 1 || got_q[0] !== mem_fn(32'h400))
            begin failures++; $display("FAIL clr_next got_n=%0d exp_n=1", got_q.size()); end
    endtask

    task automatic test_random();
        logic [31:0] sent [$];
        int bad_d, bad_a;
        reset_dut();
        for (int i = 0; i < 40; i++) begin
            sent.push_back({8'h00, 24'($urandom)});
            feed_q.push_back(sent[i]);
        end
        rand_mode = 1'b1;
        wait_done(40, 3000);
        rand_mode = 1'b0;
        mst.gnt   = 1'b1;
        ready     = 1'b1;
        bad_d = 0;
        bad_a = 0;
        for (int i = 0; i < 40; i++) begin
            if (i >= got_q.size() || got_q[i] !== mem_fn(sent[i])) bad_d++;
            if (i >= grant_q.size() || grant_q[i] !== sent[i]) bad_a++;
        end
        checks++; if (got_q.size() != 40) begin failures++; $display("FAIL rand_count got=%0d exp=40", got_q.size()); end
        checks++; if (bad_d != 0) begin failures++; $display("FAIL rand_data got_bad=%0d exp=0", bad_d); end
        checks++; if (bad_a != 0) begin failures++; $display("FAIL rand_issue_order got_bad=%0d exp=0", bad_a); end
        checks++; if (credit_viol != 0) begin failures++; $display("FAIL rand_credit got_viol=%0d exp=0", credit_viol); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        clear       = 1'b0;
        ready       = 1'b1;
        rand_mode   = 1'b0;
        last_push   = 1'b0;
        last_grant  = 1'b0;
        inflight    = 0;
        resp_held   = 0;
        n_grants    = 0;
        credit_viol = 0;
        slv.req     = 1'b0;
        slv.add     = 32'h0;
        slv.wen     = 1'b1;
        slv.be      = 4'hF;
        slv.data    = 32'h0;
        mst.gnt     = 1'b1;
        mst.r_valid = 1'b0;
        mst.r_data  = 32'h0;

        test_reset();
        test_single_load();
        test_req_backpressure();
        test_credit_limit();
        test_back_to_back();
        test_reset_mid();
        test_clear();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hwpe_stream_tcdm_load_buffer.md
Name: hwpe_stream_tcdm_load_buffer

Overview:
Load-side decoupling buffer between an HWPE load port (TCDM slave side) and the TCDM interconnect (master side).
- Load requests are queued in a request FIFO and issued to TCDM under credit control.
- Read responses are queued in a response FIFO and returned in order to the HWPE consumer, which applies backpressure via ready_i.
- It absorbs interconnect stalls (gnt=0) and consumer stalls (ready_i=0) while guaranteeing the response FIFO never overflows.

Parameters:
REQ_DEPTH, 4, request FIFO entries (power of 2, >=2); each entry holds add[31:0] and be[3:0].
RESP_DEPTH, 4, response FIFO entries (power of 2, >=2); each entry holds r_data[31:0]; also the maximum of in-flight plus buffered responses.

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  reset, synchronous, active-high
clear_i  input  1  synchronous soft clear, same effect as rst_i
tcdm_slave  hwpe_stream_intf_tcdm.slave  intf  HWPE side: req, gnt, add[31:0], wen, be[3:0], data[31:0] (ignored), r_data[31:0], r_valid
ready_i  input  1  consumer accepts tcdm_slave.r_data this cycle
tcdm_master  hwpe_stream_intf_tcdm.master  intf  TCDM side, same signal set
req_empty_o  output  1  request FIFO empty
resp_full_o  output  1  response FIFO full
pending_o  output  $clog2(RESP_DEPTH)+1  granted master requests awaiting r_valid

Behaviour:
- Reset (rst_i or clear_i high at a clock edge):
  - Both FIFOs are emptied.
  - The pending counter is zeroed.
- Outputs after reset:
  - tcdm_slave.gnt=1, tcdm_slave.r_valid=0, r_data=0.
  - tcdm_master.req=0.
  - req_empty_o=1, resp_full_o=0, pending_o=0.
- tcdm_slave.gnt = !req_full && !clear_i.
  - gnt drops when the request FIFO is full, even if a pop occurs in the same cycle (no pass-through).
- Request push: on tcdm_slave.req && gnt, {be, add} is written to the request FIFO. slave.wen is ignored (load assumed).
- Issue credit: credit_ok = (pending + resp_count) < RESP_DEPTH.
- Master request channel:
  - tcdm_master.req = !req_empty && credit_ok.
  - add and be come from the request FIFO head.
  - tcdm_master.wen = 1 (read); tcdm_master.data = 0.
- Request pop: on tcdm_master.req && gnt.
  - req and head data stay stable while gnt=0.
- Request FIFO has no fall-through. A slave grant at cycle 0 into an empty FIFO gives master req at cycle 1 at the earliest.
- Master response protocol: TCDM returns r_valid exactly one cycle after each master grant, in order.
- Pending counter:
  - +1 on master grant, -1 on master r_valid.
  - Both in the same cycle leave it unchanged.
- Response push:
  - tcdm_master.r_valid with pending>0 writes r_data into the response FIFO.
  - r_valid with pending==0 (stale response after reset/clear) is discarded with no state change.
- Response FIFO:
  - Registered, no fall-through: master r_valid at cycle t gives slave r_valid at cycle t+1 at the earliest.
  - tcdm_slave.r_valid = !resp_empty; r_data is the head entry, held stable until popped.
  - Pop on r_valid && ready_i. Push and pop in the same cycle keep the count.
- Overflow: a response push into a full FIFO is impossible by credit construction. The simulation assertion flags it; the design does not handle it.
- Ordering: responses leave in exactly the order their requests were granted on the slave side.
- Pointers wrap modulo depth. Full/empty are derived from an occupancy counter (0..DEPTH).

Test Plan:
- Single load: slave req add=0x100 at cycle 0, master gnt=1 always, r_data=0xCAFE0001 at cycle 2, ready_i=1 -> master req at cycle 1 with add=0x100, wen=1; slave r_valid with 0xCAFE0001 at cycle 3; pending_o 1 then 0.
- Request backpressure: master gnt=0, 6 slave reqs with REQ_DEPTH=4 -> 4 granted, slave gnt=0 from the 5th; after gnt=1, addresses issued in order with no loss.
- Credit limit: ready_i=0, 8 loads, RESP_DEPTH=4 -> exactly 4 master grants, then master req=0 and resp_full_o=1; ready_i=1 resumes issue; all 8 data returned in order.
- Simultaneous events: steady stream with gnt=1, ready_i=1 -> one load per cycle sustained, pending_o constant at 1, resp count never exceeds 1.
- Reset mid-operation: rst_i asserted the cycle after a master grant, stale r_valid=0xDEAD arrives -> discarded; all outputs at reset values; next load returns correct data.
- clear_i with both FIFOs non-empty -> same effect as rst_i in one cycle; slave gnt=0 during the clear cycle.
